// File: rtl/pipe_pkg.sv
// Shared types for the flow-controlled pipeline stage register.
// Field widths describe the ID/EX bundle, the widest inter-stage payload.
package pipe_pkg;

    localparam int CTRL_W = 10;
    localparam int IMM_W  = 32;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid storage: main feeds downstream, skid catches the
// payload accepted while downstream stalls.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W      = 121,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 accept,
    input  logic                 drain,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    output logic [1:0]           occupancy,
    output logic                 room
);

    skid_state_t          state;
    skid_state_t          state_nxt;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 main_ld;
    logic                 skid_ld;
    logic                 main_from_skid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        main_ld   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_TWO;
                        skid_ld   = 1'b1;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_nxt      = ST_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            if (main_ld) begin
                main_q <= in_payload;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= in_payload;
            end
        end
    end

    assign out_payload = main_q;
    assign out_valid   = (state != ST_EMPTY);
    assign room        = (state != ST_TWO);

    always_comb begin
        occupancy = 2'd0;
        unique case (state)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline register with bubble, flush, optional skid
// buffer and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W      = $bits(id_ex_payload_t),
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   bubble,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    logic accept;
    logic drain;
    logic room;

    assign in_ready = room & ~bubble & ~flush;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(
                .PAYLOAD_W      (PAYLOAD_W),
                .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
            ) u_skid (
                .clk         (clk),
                .reset       (reset),
                .flush       (flush),
                .accept      (accept),
                .drain       (drain),
                .in_payload  (in_payload),
                .out_payload (out_payload),
                .out_valid   (out_valid),
                .occupancy   (occupancy),
                .room        (room)
            );
        end else begin : g_reg
            logic                 valid_q;
            logic [PAYLOAD_W-1:0] main_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    if (CLEAR_ON_FLUSH != 0) begin
                        main_q <= '0;
                    end
                end else if (accept) begin
                    valid_q <= 1'b1;
                    main_q  <= in_payload;
                end else if (drain) begin
                    valid_q <= 1'b0;
                end
            end

            // Room depends on out_ready: a combinational ready path.
            assign room        = ~valid_q | out_ready;
            assign out_valid   = valid_q;
            assign out_payload = main_q;
            assign occupancy   = {1'b0, valid_q};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a skid instance (4-bit counter)
// and a single-register instance share the same stimulus.
module tb_pipe_stage_reg;

    localparam int PW = 121;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          flush;
    logic          bubble;
    logic          in_valid;
    logic          out_ready;
    logic [PW-1:0] in_payload;

    logic          s_in_ready;
    logic          s_out_valid;
    logic [PW-1:0] s_out_payload;
    logic [1:0]    s_occupancy;
    logic [3:0]    s_stall_count;

    logic          r_in_ready;
    logic          r_out_valid;
    logic [PW-1:0] r_out_payload;
    logic [1:0]    r_occupancy;
    logic [15:0]   r_stall_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [PW-1:0] q_s [$];
    logic [PW-1:0] q_r [$];

    pipe_stage_reg #(
        .PAYLOAD_W      (PW),
        .SKID           (1),
        .CLEAR_ON_FLUSH (1),
        .STALL_CNT_W    (4)
    ) dut_s (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bubble      (bubble),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .in_payload  (in_payload),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_payload (s_out_payload),
        .occupancy   (s_occupancy),
        .stall_count (s_stall_count)
    );

    pipe_stage_reg #(
        .PAYLOAD_W      (PW),
        .SKID           (0),
        .CLEAR_ON_FLUSH (1),
        .STALL_CNT_W    (16)
    ) dut_r (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bubble      (bubble),
        .in_valid    (in_valid),
        .in_ready    (r_in_ready),
        .in_payload  (in_payload),
        .out_valid   (r_out_valid),
        .out_ready   (out_ready),
        .out_payload (r_out_payload),
        .occupancy   (r_occupancy),
        .stall_count (r_stall_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        flush      = 1'b0;
        bubble     = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_payload = '0;
        reset      = 1'b1;
        #2;
        reset = 1'b0;
        q_s.delete();
        q_r.delete();
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        flush      = 1'b0;
        bubble     = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        in_payload = PW'(8'h99);
        tick();
        n_total++;
        if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0 ||
            s_stall_count !== 4'd0 || s_out_payload !== '0)
            $display("FAIL reset_skid got v=%b occ=%0d st=%0d p=%0h exp all 0",
                     s_out_valid, s_occupancy, s_stall_count, s_out_payload);
        else n_pass++;
        n_total++;
        if (r_out_valid !== 1'b0 || r_occupancy !== 2'd0 ||
            r_stall_count !== 16'd0 || r_out_payload !== '0)
            $display("FAIL reset_reg got v=%b occ=%0d st=%0d p=%0h exp all 0",
                     r_out_valid, r_occupancy, r_stall_count, r_out_payload);
        else n_pass++;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        n_total++;
        if ({s_in_ready, r_in_ready} !== 2'b11)
            $display("FAIL reset_in_ready got=%b%b exp=11", s_in_ready, r_in_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_streaming;
        logic [2:0] exp_st;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid   = (i < 3);
            in_payload = PW'(i + 1);
            #1;
            n_total++;
            if ({s_in_ready, r_in_ready} !== 2'b11)
                $display("FAIL stream_in_ready cyc=%0d got=%b%b exp=11",
                         i, s_in_ready, r_in_ready);
            else n_pass++;
            exp_st = {q_s.size() != 0, 2'(q_s.size())};
            n_total++;
            if ({s_out_valid, s_occupancy} !== exp_st)
                $display("FAIL stream_skid_state cyc=%0d got=%b exp=%b",
                         i, {s_out_valid, s_occupancy}, exp_st);
            else n_pass++;
            exp_st = {q_r.size() != 0, 2'(q_r.size())};
            n_total++;
            if ({r_out_valid, r_occupancy} !== exp_st)
                $display("FAIL stream_reg_state cyc=%0d got=%b exp=%b",
                         i, {r_out_valid, r_occupancy}, exp_st);
            else n_pass++;
            if (q_s.size() != 0) begin
                n_total++;
                if (s_out_payload !== q_s[0])
                    $display("FAIL stream_skid_data cyc=%0d got=%0h exp=%0h",
                             i, s_out_payload, q_s[0]);
                else n_pass++;
                void'(q_s.pop_front());
            end
            if (q_r.size() != 0) begin
                n_total++;
                if (r_out_payload !== q_r[0])
                    $display("FAIL stream_reg_data cyc=%0d got=%0h exp=%0h",
                             i, r_out_payload, q_r[0]);
                else n_pass++;
                void'(q_r.pop_front());
            end
            if (i < 3) begin
                q_s.push_back(PW'(i + 1));
                q_r.push_back(PW'(i + 1));
            end
            tick();
        end
    endtask

    task automatic test_back_pressure;
        logic [6:0] iv;
        logic [6:0] ordy;
        logic [6:0] exp_ir;
        logic [7:0] pl [7];
        logic [3:0] exp_stall [7];
        logic [2:0] exp_st;
        iv        = 7'b0000111;
        ordy      = 7'b1110000;
        exp_ir    = 7'b1100011;
        pl        = '{8'h0A, 8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_stall = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid   = iv[i];
            out_ready  = ordy[i];
            in_payload = PW'(pl[i]);
            #1;
            n_total++;
            if (s_in_ready !== exp_ir[i])
                $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b",
                         i, s_in_ready, exp_ir[i]);
            else n_pass++;
            exp_st = {q_s.size() != 0, 2'(q_s.size())};
            n_total++;
            if ({s_out_valid, s_occupancy} !== exp_st)
                $display("FAIL bp_state cyc=%0d got=%b exp=%b",
                         i, {s_out_valid, s_occupancy}, exp_st);
            else n_pass++;
            n_total++;
            if (s_stall_count !== exp_stall[i])
                $display("FAIL bp_stall cyc=%0d got=%0d exp=%0d",
                         i, s_stall_count, exp_stall[i]);
            else n_pass++;
            if (q_s.size() != 0) begin
                n_total++;
                if (s_out_payload !== q_s[0])
                    $display("FAIL bp_data cyc=%0d got=%0h exp=%0h",
                             i, s_out_payload, q_s[0]);
                else n_pass++;
                if (ordy[i]) void'(q_s.pop_front());
            end
            if (iv[i] && exp_ir[i]) q_s.push_back(PW'(pl[i]));
            tick();
        end
    endtask

    task automatic test_bubble;
        do_reset();
        in_valid   = 1'b1;
        in_payload = PW'(8'h55);
        out_ready  = 1'b1;
        #1;
        n_total++;
        if ({r_in_ready, r_out_valid} !== 2'b10)
            $display("FAIL bub_load got rdy/v=%b exp=10", {r_in_ready, r_out_valid});
        else n_pass++;
        q_r.push_back(PW'(8'h55));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        n_total++;
        if ({r_in_ready, r_out_valid} !== 2'b01)
            $display("FAIL bub_full_stall got rdy/v=%b exp=01", {r_in_ready, r_out_valid});
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++;
        if (r_in_ready !== 1'b1)
            $display("FAIL bub_comb_ready got=%b exp=1", r_in_ready);
        else n_pass++;
        bubble     = 1'b1;
        in_valid   = 1'b1;
        in_payload = PW'(8'h66);
        #1;
        n_total++;
        if ({s_in_ready, r_in_ready} !== 2'b00)
            $display("FAIL bub_in_ready got=%b%b exp=00", s_in_ready, r_in_ready);
        else n_pass++;
        n_total++;
        if (r_out_valid !== 1'b1 || r_out_payload !== q_r[0])
            $display("FAIL bub_drain got v=%b p=%0h exp v=1 p=%0h",
                     r_out_valid, r_out_payload, q_r[0]);
        else n_pass++;
        void'(q_r.pop_front());
        tick();
        bubble   = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        n_total++;
        if ({r_out_valid, r_occupancy} !== 3'b000 || r_out_payload !== PW'(8'h55))
            $display("FAIL bub_empty got v/occ=%b p=%0h exp 000 p=55",
                     {r_out_valid, r_occupancy}, r_out_payload);
        else n_pass++;
        n_total++;
        if ({s_out_valid, s_occupancy} !== 3'b000)
            $display("FAIL bub_skid_empty got=%b exp=000", {s_out_valid, s_occupancy});
        else n_pass++;
        tick();
    endtask

    task automatic test_flush;
        do_reset();
        in_valid   = 1'b1;
        in_payload = PW'(8'h0C);
        #1;
        q_s.push_back(PW'(8'h0C));
        q_r.push_back(PW'(8'h0C));
        tick();
        in_payload = PW'(8'h0D);
        #1;
        n_total++;
        if ({s_in_ready, r_in_ready} !== 2'b10)
            $display("FAIL fl_fill_ready got=%b%b exp=10", s_in_ready, r_in_ready);
        else n_pass++;
        q_s.push_back(PW'(8'h0D));
        tick();
        flush      = 1'b1;
        in_payload = PW'(8'h77);
        #1;
        n_total++;
        if ({s_in_ready, r_in_ready, s_occupancy} !== 4'b0010)
            $display("FAIL fl_pre got rdy=%b%b occ=%0d exp rdy=00 occ=2",
                     s_in_ready, r_in_ready, s_occupancy);
        else n_pass++;
        n_total++;
        if (s_out_payload !== q_s[0])
            $display("FAIL fl_pre_data got=%0h exp=%0h", s_out_payload, q_s[0]);
        else n_pass++;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        q_s.delete();
        q_r.delete();
        #1;
        n_total++;
        if ({s_out_valid, s_occupancy} !== 3'b000 || s_out_payload !== '0)
            $display("FAIL fl_skid got v/occ=%b p=%0h exp 000 p=0",
                     {s_out_valid, s_occupancy}, s_out_payload);
        else n_pass++;
        n_total++;
        if ({r_out_valid, r_occupancy} !== 3'b000 || r_out_payload !== '0)
            $display("FAIL fl_reg got v/occ=%b p=%0h exp 000 p=0",
                     {r_out_valid, r_occupancy}, r_out_payload);
        else n_pass++;
        n_total++;
        if (s_stall_count !== 4'd2 || r_stall_count !== 16'd2)
            $display("FAIL fl_stall_kept got=%0d,%0d exp=2,2",
                     s_stall_count, r_stall_count);
        else n_pass++;
        in_valid   = 1'b1;
        in_payload = PW'(8'h88);
        out_ready  = 1'b1;
        #1;
        n_total++;
        if ({s_in_ready, r_in_ready} !== 2'b11)
            $display("FAIL fl_resume_ready got=%b%b exp=11", s_in_ready, r_in_ready);
        else n_pass++;
        q_s.push_back(PW'(8'h88));
        q_r.push_back(PW'(8'h88));
        tick();
        in_valid = 1'b0;
        #1;
        n_total++;
        if (s_out_valid !== 1'b1 || s_out_payload !== q_s[0])
            $display("FAIL fl_resume_skid got v=%b p=%0h exp v=1 p=%0h",
                     s_out_valid, s_out_payload, q_s[0]);
        else n_pass++;
        n_total++;
        if (r_out_valid !== 1'b1 || r_out_payload !== q_r[0])
            $display("FAIL fl_resume_reg got v=%b p=%0h exp v=1 p=%0h",
                     r_out_valid, r_out_payload, q_r[0]);
        else n_pass++;
        void'(q_s.pop_front());
        void'(q_r.pop_front());
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        in_valid   = 1'b1;
        in_payload = PW'(8'h11);
        tick();
        in_payload = PW'(8'h22);
        tick();
        in_valid = 1'b0;
        #1;
        n_total++;
        if (s_occupancy !== 2'd2 || s_stall_count !== 4'd1)
            $display("FAIL ar_pre got occ=%0d st=%0d exp occ=2 st=1",
                     s_occupancy, s_stall_count);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0 ||
            s_stall_count !== 4'd0 || s_out_payload !== '0)
            $display("FAIL ar_skid got v=%b occ=%0d st=%0d p=%0h exp all 0",
                     s_out_valid, s_occupancy, s_stall_count, s_out_payload);
        else n_pass++;
        n_total++;
        if (r_out_valid !== 1'b0 || r_stall_count !== 16'd0 || r_out_payload !== '0)
            $display("FAIL ar_reg got v=%b st=%0d p=%0h exp all 0",
                     r_out_valid, r_stall_count, r_out_payload);
        else n_pass++;
        reset = 1'b0;
        q_s.delete();
        q_r.delete();
        tick();
        n_total++;
        if ({s_out_valid, s_occupancy} !== 3'b000)
            $display("FAIL ar_post got=%b exp=000", {s_out_valid, s_occupancy});
        else n_pass++;
    endtask

    task automatic test_saturation;
        logic [3:0] exp_cnt;
        do_reset();
        in_valid   = 1'b1;
        in_payload = PW'(8'h05);
        q_s.push_back(PW'(8'h05));
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_cnt = (k < 15) ? 4'(k) : 4'd15;
            n_total++;
            if (s_stall_count !== exp_cnt)
                $display("FAIL sat_count k=%0d got=%0d exp=%0d",
                         k, s_stall_count, exp_cnt);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (s_out_valid !== 1'b1 || s_out_payload !== q_s[0])
            $display("FAIL sat_drain got v=%b p=%0h exp v=1 p=%0h",
                     s_out_valid, s_out_payload, q_s[0]);
        else n_pass++;
        void'(q_s.pop_front());
        tick();
        n_total++;
        if (s_out_valid !== 1'b0 || s_stall_count !== 4'd15)
            $display("FAIL sat_end got v=%b st=%0d exp v=0 st=15",
                     s_out_valid, s_stall_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
